// File: rtl/trace_checker.sv
// trace_checker: parses ASCII register-write and memory-write trace records and reports time/pc/addr/grf errors.
// Defining TRACE_CHECKER_STATS_EN adds saturating rec_cnt/err_cnt statistics outputs.
module trace_checker #(
    parameter int          TIME_DIG_MAX = 4,
    parameter int          REG_DIG_MAX  = 4,
    parameter int          HEX_DIG      = 8,
    parameter logic [31:0] PC_MIN       = 32'h3000,
    parameter logic [31:0] PC_MAX       = 32'h4fff,
    parameter logic [31:0] ADDR_MIN     = 32'h0000,
    parameter logic [31:0] ADDR_MAX     = 32'h2fff
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  char,
    input  logic [15:0] freq,
    output logic [1:0]  format_type,
    output logic [3:0]  error_code
`ifdef TRACE_CHECKER_STATS_EN
    ,
    output logic [15:0] rec_cnt,
    output logic [15:0] err_cnt
`endif
);

    localparam int TW = 4 * TIME_DIG_MAX;
    localparam int RW = 4 * REG_DIG_MAX;
    localparam int AW = 4 * HEX_DIG;
    localparam int CW = 8;

    localparam logic [7:0] C_CARET = 8'h5e;
    localparam logic [7:0] C_AT    = 8'h40;
    localparam logic [7:0] C_COLON = 8'h3a;
    localparam logic [7:0] C_SPACE = 8'h20;
    localparam logic [7:0] C_DOLLAR = 8'h24;
    localparam logic [7:0] C_STAR  = 8'h2a;
    localparam logic [7:0] C_LT    = 8'h3c;
    localparam logic [7:0] C_EQ    = 8'h3d;
    localparam logic [7:0] C_HASH  = 8'h23;

    typedef enum logic [3:0] {
        IDLE, TIME, PC, COLON, PRE_TGT, REG, MEM, PRE_LT, ARROW, PRE_DATA, DATA, DONE
    } state_t;

    state_t          state;
    state_t          next_state;
    logic            take;
    logic [CW-1:0]   dig_cnt;
    logic [TW-1:0]   time_acc;
    logic [RW-1:0]   reg_acc;
    logic [AW-1:0]   pc_acc;
    logic [AW-1:0]   addr_acc;
    logic            is_mem;
    logic            fire;
    logic [15:0]     freq_mask;
    logic            time_err;
    logic            pc_err;
    logic            addr_err;
    logic            grf_err;
    logic [1:0]      format_next;
    logic [3:0]      error_next;

    function automatic logic is_dec(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    function automatic logic is_hex(input logic [7:0] c);
        return is_dec(c) || ((c >= 8'h61) && (c <= 8'h66)) || ((c >= 8'h41) && (c <= 8'h46));
    endfunction

    // Letters a-f and A-F both have low nibble 1..6, so adding 9 yields 10..15.
    function automatic logic [3:0] hex_val(input logic [7:0] c);
        return is_dec(c) ? c[3:0] : (c[3:0] + 4'd9);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // take marks a digit accepted into the current field; dig_cnt counts only consecutive digits.
    always_comb begin
        next_state = IDLE;
        take       = 1'b0;
        if (char == C_CARET) begin
            next_state = TIME;
        end else begin
            case (state)
                IDLE: next_state = IDLE;
                TIME: begin
                    if (is_dec(char) && (dig_cnt < CW'(TIME_DIG_MAX))) begin
                        take       = 1'b1;
                        next_state = TIME;
                    end else if ((char == C_AT) && (dig_cnt != '0)) begin
                        next_state = PC;
                    end
                end
                PC: begin
                    if (is_hex(char)) begin
                        take       = 1'b1;
                        next_state = (dig_cnt == CW'(HEX_DIG - 1)) ? COLON : PC;
                    end
                end
                COLON: if (char == C_COLON) next_state = PRE_TGT;
                PRE_TGT: begin
                    if (char == C_SPACE)       next_state = PRE_TGT;
                    else if (char == C_DOLLAR) next_state = REG;
                    else if (char == C_STAR)   next_state = MEM;
                end
                REG: begin
                    if (is_dec(char) && (dig_cnt < CW'(REG_DIG_MAX))) begin
                        take       = 1'b1;
                        next_state = REG;
                    end else if ((char == C_SPACE) && (dig_cnt != '0)) begin
                        next_state = PRE_LT;
                    end else if ((char == C_LT) && (dig_cnt != '0)) begin
                        next_state = ARROW;
                    end
                end
                MEM: begin
                    if (is_hex(char)) begin
                        take       = 1'b1;
                        next_state = (dig_cnt == CW'(HEX_DIG - 1)) ? PRE_LT : MEM;
                    end
                end
                PRE_LT: begin
                    if (char == C_SPACE)   next_state = PRE_LT;
                    else if (char == C_LT) next_state = ARROW;
                end
                ARROW: if (char == C_EQ) next_state = PRE_DATA;
                PRE_DATA, DATA: begin
                    if ((state == PRE_DATA) && (char == C_SPACE)) begin
                        next_state = PRE_DATA;
                    end else if (is_hex(char)) begin
                        take       = 1'b1;
                        next_state = (dig_cnt == CW'(HEX_DIG - 1)) ? DONE : DATA;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || (char == C_CARET)) begin
            dig_cnt  <= '0;
            time_acc <= '0;
            reg_acc  <= '0;
            pc_acc   <= '0;
            addr_acc <= '0;
            is_mem   <= 1'b0;
        end else begin
            dig_cnt <= take ? (dig_cnt + CW'(1)) : '0;
            if (take) begin
                case (state)
                    TIME:    time_acc <= (time_acc * TW'(10)) + TW'(hex_val(char));
                    PC:      pc_acc   <= {pc_acc[AW-5:0], hex_val(char)};
                    REG:     reg_acc  <= (reg_acc * RW'(10)) + RW'(hex_val(char));
                    MEM:     addr_acc <= {addr_acc[AW-5:0], hex_val(char)};
                    default: ;
                endcase
            end
            if (state == PRE_TGT) begin
                if (char == C_STAR)        is_mem <= 1'b1;
                else if (char == C_DOLLAR) is_mem <= 1'b0;
            end
        end
    end

    // Range checks use (x - MIN) <= (MAX - MIN) so a zero lower bound needs no special case.
    always_comb begin
        freq_mask = (freq >> 1) - 16'd1;
        time_err  = (freq >= 16'd2) && ((32'(time_acc) & 32'(freq_mask)) != 32'd0);
        pc_err    = (pc_acc[1:0] != 2'b00) ||
                    ((pc_acc - AW'(PC_MIN)) > AW'(PC_MAX - PC_MIN));
        addr_err  = (addr_acc[1:0] != 2'b00) ||
                    ((addr_acc - AW'(ADDR_MIN)) > AW'(ADDR_MAX - ADDR_MIN));
        grf_err   = (reg_acc > RW'(31));
    end

    always_comb begin
        fire        = (state == DONE) && (char == C_HASH);
        format_next = 2'd0;
        error_next  = 4'd0;
        if (fire) begin
            format_next = is_mem ? 2'd2 : 2'd1;
            error_next  = {(!is_mem) && grf_err, is_mem && addr_err, pc_err, time_err};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            format_type <= 2'd0;
            error_code  <= 4'd0;
        end else begin
            format_type <= format_next;
            error_code  <= error_next;
        end
    end

`ifdef TRACE_CHECKER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rec_cnt <= 16'd0;
            err_cnt <= 16'd0;
        end else if (fire) begin
            if (rec_cnt != 16'hffff) rec_cnt <= rec_cnt + 16'd1;
            if ((error_next != 4'd0) && (err_cnt != 16'hffff)) err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_trace_checker.sv
// tb_trace_checker: table-driven trace records with a scoreboard queue of expected outputs,
// plus hand sequences for one-cycle output, back-to-back records and reset during '#'.
module tb_trace_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  char;
    logic [15:0] freq;
    logic [1:0]  format_type;
    logic [3:0]  error_code;
`ifdef TRACE_CHECKER_STATS_EN
    logic [15:0] rec_cnt;
    logic [15:0] err_cnt;
`endif

    trace_checker dut (
        .clk(clk),
        .reset(reset),
        .char(char),
        .freq(freq),
        .format_type(format_type),
        .error_code(error_code)
`ifdef TRACE_CHECKER_STATS_EN
        ,
        .rec_cnt(rec_cnt),
        .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        string       text;
        logic [15:0] f_start;
        logic [15:0] f_hash;
        logic [1:0]  fmt;
        logic [3:0]  err;
    } vec_t;

    typedef struct {
        string      name;
        logic [1:0] fmt;
        logic [3:0] err;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    task automatic add_vec(input string name, input string text, input logic [15:0] f_start,
                           input logic [15:0] f_hash, input logic [1:0] fmt, input logic [3:0] err);
        vec_t v;
        v.name    = name;
        v.text    = text;
        v.f_start = f_start;
        v.f_hash  = f_hash;
        v.fmt     = fmt;
        v.err     = err;
        vecs.push_back(v);
    endtask

    task automatic apply_stimulus(input vec_t v);
        exp_t e;
        freq = v.f_start;
        if (v.fmt != 2'd0) begin
            e.name = v.name;
            e.fmt  = v.fmt;
            e.err  = v.err;
            exp_q.push_back(e);
        end
        for (int i = 0; i < v.text.len(); i++) begin
            char = v.text[i];
            if (i == v.text.len() - 1) freq = v.f_hash;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_output(input string name);
        char = 8'h20;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s missing_output: %0d pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_value(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h required %0h", name, got, want);
        end
    endtask

    // Scoreboard: every nonzero format_type must match the oldest pending expectation.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (format_type != 2'd0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_output: format_type %0d error_code %b, required none",
                             format_type, error_code);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if ((format_type !== e.fmt) || (error_code !== e.err)) begin
                        errors++;
                        $display("[TB] FAIL %s: format_type %0d error_code %b, required %0d %b",
                                 e.name, format_type, error_code, e.fmt, e.err);
                    end
                end
            end else begin
                checks++;
                if (error_code !== 4'd0) begin
                    errors++;
                    $display("[TB] FAIL idle_error_code: got %b required 0000", error_code);
                end
            end
        end
    end

    initial begin
        vec_t v0;
        vec_t v1;
        vec_t v2;
        vec_t vr;

        add_vec("req050",      "^1024@00003010:$2 <= 89abcdef#",       16'd2, 16'd2, 2'd1, 4'b0000);
        add_vec("req051",      "^10@00003002: *00003000<=00000000#",   16'd8, 16'd8, 2'd2, 4'b0111);
        add_vec("req052",      "^5@00003000:$32 <= 0000000A#",         16'd2, 16'd2, 2'd1, 4'b1000);
        add_vec("time5dig",    "^12345@00003000:$1 <= 00000000#",      16'd2, 16'd2, 2'd0, 4'b0000);
        add_vec("pc7hex",      "^1@0003000:$1 <= 00000000#",           16'd2, 16'd2, 2'd0, 4'b0000);
        add_vec("restart",     "^1@0000^2@00003004:$1 <= 00000001#",   16'd2, 16'd2, 2'd1, 4'b0000);
        add_vec("odd_time",    "^3@00004FFC:   $31<=DeadBeef#",        16'd4, 16'd4, 2'd1, 4'b0001);
        add_vec("pc_high",     "^7@00005000:*00002FFC <=  00000000#",  16'd1, 16'd1, 2'd2, 4'b0010);
        add_vec("pc_low",      "^9999@00002FFC:$0<=ffffffff#",         16'd0, 16'd0, 2'd1, 4'b0010);
        add_vec("addr_high",   "^8@00003000:*00003000<=12345678#",     16'd16, 16'd16, 2'd2, 4'b0100);
        add_vec("reg5dig",     "^1@00003000:$12345<=00000000#",        16'd2, 16'd2, 2'd0, 4'b0000);
        add_vec("data7hex",    "^1@00003000:$1 <= 0000000#",           16'd2, 16'd2, 2'd0, 4'b0000);
        add_vec("data9hex",    "^1@00003000:$1 <= 000000001#",         16'd2, 16'd2, 2'd0, 4'b0000);
        add_vec("data_badhex", "^1@00003000:$1 <= 0000000G#",          16'd2, 16'd2, 2'd0, 4'b0000);
        add_vec("addr_misal",  "^2@00003000:*00000002<=00000000#",     16'd2, 16'd2, 2'd2, 4'b0100);
        add_vec("pc9hex",      "^1@000030000:$1<=00000000#",           16'd2, 16'd2, 2'd0, 4'b0000);
        add_vec("time0dig",    "^@00003000:$1<=00000000#",             16'd2, 16'd2, 2'd0, 4'b0000);
        add_vec("freq_late_8", "^10@00003000:$1<=00000000#",           16'd2, 16'd8, 2'd1, 4'b0001);
        add_vec("freq_late_2", "^10@00003000:$1<=00000000#",           16'd8, 16'd2, 2'd1, 4'b0000);
        add_vec("freq_8000",   "^9999@00003000:$0<=00000000#",         16'h8000, 16'h8000, 2'd1, 4'b0001);

        reset = 1'b1;
        char  = 8'h00;
        freq  = 16'd2;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_value("reset_format_type", 16'(format_type), 16'd0);
        check_value("reset_error_code", 16'(error_code), 16'd0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // One-cycle output pulse: visible right after the '#' edge, gone one cycle later.
        v0 = vecs[0];
        apply_stimulus(v0);
        check_value("pulse_format_type", 16'(format_type), 16'd1);
        char = 8'h20;
        @(posedge clk);
        #1;
        check_value("pulse_clear_format_type", 16'(format_type), 16'd0);
        check_value("pulse_clear_error_code", 16'(error_code), 16'd0);
        check_output("pulse");

        v1 = vecs[1];
        apply_stimulus(v1);
        check_output("req051");
`ifdef TRACE_CHECKER_STATS_EN
        check_value("rec_cnt_after_2", rec_cnt, 16'd2);
        check_value("err_cnt_after_2", err_cnt, 16'd1);
`endif
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
`ifdef TRACE_CHECKER_STATS_EN
        check_value("rec_cnt_reset", rec_cnt, 16'd0);
        check_value("err_cnt_reset", err_cnt, 16'd0);
`endif

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i]);
            check_output(vecs[i].name);
        end

        // Back-to-back: second '^' arrives on the cycle right after the first '#'.
        v2 = vecs[2];
        apply_stimulus(v0);
        apply_stimulus(v2);
        check_output("back_to_back");

        // Reset on the '#' cycle discards the record.
        vr.name    = "reset_on_hash";
        vr.text    = "^2@00003004:$1 <= 00000001";
        vr.f_start = 16'd2;
        vr.f_hash  = 16'd2;
        vr.fmt     = 2'd0;
        vr.err     = 4'd0;
        apply_stimulus(vr);
        char  = 8'h23;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_value("reset_hash_format_type", 16'(format_type), 16'd0);
        check_value("reset_hash_error_code", 16'(error_code), 16'd0);
        reset = 1'b0;
        char  = 8'h23;
        @(posedge clk);
        #1;
        check_output("reset_hash_discard");
        apply_stimulus(v0);
        check_output("after_reset_record");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trace_checker.md
TRACE_CHECKER -- requirements
Module: trace_checker

Interface
REQ-001 Parameters (name, default, meaning): TIME_DIG_MAX 4, max decimal digits of time field; REG_DIG_MAX 4, max decimal digits of register field; HEX_DIG 8, exact hex digit count of pc/addr/data fields; PC_MIN 32'h3000, PC_MAX 32'h4fff, legal pc range inclusive; ADDR_MIN 32'h0000, ADDR_MAX 32'h2fff, legal memory address range inclusive.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high.
REQ-004 char  input  8  ASCII character, one sampled per clock.
REQ-005 freq  input  16  clock-period setting for time check; power of two.
REQ-006 format_type  output  2  0 none, 1 register-write record, 2 memory-write record.
REQ-007 error_code  output  4  bit0 time, bit1 pc, bit2 addr, bit3 grf.

Function
REQ-010 Register record: '^' time '@' pc ':' sp* '$' reg sp* '<=' sp* data '#'; memory record identical with '*' addr in place of '$' reg.
REQ-011 time: 1..TIME_DIG_MAX decimal digits; reg: 1..REG_DIG_MAX decimal digits; pc, addr, data: exactly HEX_DIG hex digits, 0-9/a-f/A-F accepted; sp* is zero or more ' '.
REQ-012 States: IDLE, TIME, PC, COLON, PRE_TGT, REG, MEM, PRE_LT, ARROW, PRE_DATA, DATA, DONE; any char violating the grammar moves to IDLE.
REQ-013 '^' in any state restarts the record: state TIME, all accumulators and digit counters cleared.
REQ-014 Too many/too few digits in any field is a grammar violation (-> IDLE, no output).
REQ-015 Accumulators: time width 4*TIME_DIG_MAX bits (acc*10+d), reg width 4*REG_DIG_MAX bits, pc/addr 4*HEX_DIG bits (acc<<4|d).
REQ-016 On the clock edge sampling a valid '#' in DONE, format_type and error_code are registered and held for exactly one cycle, then return to 0; state returns to IDLE.
REQ-017 time error: freq>=2 and (time & (freq/2-1)) != 0; freq<2 never flags time error.
REQ-018 pc error: pc[1:0]!=0 or pc<PC_MIN or pc>PC_MAX.
REQ-019 addr error (memory records only): addr[1:0]!=0 or addr<ADDR_MIN or addr>ADDR_MAX.
REQ-020 grf error (register records only): reg > 31.
REQ-021 error_code is 0 whenever format_type is 0.
REQ-022 freq is sampled at the '#' edge; mid-record changes affect only that evaluation.
REQ-023 Back-to-back records: '^' on the cycle after '#' is accepted with no idle cycle.

Reset
REQ-030 reset high: state IDLE, format_type 0, error_code 0, accumulators 0, statistics counters 0.
REQ-031 reset wins over a simultaneous '#' or '^'; a record in progress is discarded.

Configuration
REQ-040 Macro TRACE_CHECKER_STATS_EN defined: extra outputs rec_cnt[15:0] (valid records) and err_cnt[15:0] (valid records with error_code!=0), incremented on the output edge, saturating at 16'hffff.
REQ-041 Macro undefined: those ports and counters do not exist; all other behaviour identical.

Verification
REQ-050 freq=2, "^1024@00003010:$2 <= 89abcdef#" -> next cycle format_type=1, error_code=0; following cycle both 0.
REQ-051 freq=8, "^10@00003002: *00003000<=00000000#" -> format_type=2, error_code=4'b0111.
REQ-052 freq=2, "^5@00003000:$32 <= 0000000A#" -> format_type=1, error_code=4'b1000.
REQ-053 "^12345@00003000:$1 <= 00000000#" (5 time digits) or "^1@0003000:$1 <= 00000000#" (7 hex) -> format_type stays 0.
REQ-054 "^1@0000^2@00003004:$1 <= 00000001#" -> restart honoured, format_type=1, error_code=0; reset asserted on the '#' cycle of a record -> no output.
REQ-055 With TRACE_CHECKER_STATS_EN: REQ-050 then REQ-051 -> rec_cnt=2, err_cnt=1; after reset both 0.
